// File: rtl/lisa_ssa_operand_fetch_if.sv
// Bus bundle for the SSA operand-fetch stage.
// Groups three signal sets: the decode handshake (in_*), the register-file
// read ports (raddr/rdata/rvalid) and the execute handshake (out_*).
// stall_count is carried here as well.
// master: the operand-fetch stage.  slave: the surrounding pipeline/regfile.
interface lisa_ssa_operand_fetch_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 8
);
  // Decode side
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_src0;
  logic [7:0]        in_src1;
  logic [7:0]        in_src2;
  logic [2:0]        in_use;
  logic [TAG_W-1:0]  in_tag;

  // Register-file read ports
  logic [7:0]        raddr0;
  logic [7:0]        raddr1;
  logic [7:0]        raddr2;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              rvalid0;
  logic              rvalid1;
  logic              rvalid2;

  // Execute side
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_op0;
  logic [DATA_W-1:0] out_op1;
  logic [DATA_W-1:0] out_op2;
  logic [TAG_W-1:0]  out_tag;
  logic              out_err;
  logic [31:0]       stall_count;

  modport master (
    input  in_valid, in_src0, in_src1, in_src2, in_use, in_tag,
    input  rdata0, rdata1, rdata2, rvalid0, rvalid1, rvalid2,
    input  out_ready,
    output in_ready, raddr0, raddr1, raddr2,
    output out_valid, out_op0, out_op1, out_op2, out_tag, out_err, stall_count
  );

  modport slave (
    output in_valid, in_src0, in_src1, in_src2, in_use, in_tag,
    output rdata0, rdata1, rdata2, rvalid0, rvalid1, rvalid2,
    output out_ready,
    input  in_ready, raddr0, raddr1, raddr2,
    input  out_valid, out_op0, out_op1, out_op2, out_tag, out_err, stall_count
  );
endinterface

// File: rtl/lisa_ssa_operand_fetch.sv
// Operand-fetch stage between decode and execute.
// The stage latches one instruction with up to three SSA source IDs.
// It drives the register-file read ports from those latched IDs and waits
// until every used operand is valid. It then captures the operand bundle
// and offers it to execute over a valid/ready handshake.
// A wait of TIMEOUT unmet cycles releases the bundle early with out_err set.
// TIMEOUT = 0 means the stage never times out.
// Ports:
//   clk, rst_n : clock; asynchronous active-low reset
//   bus        : master view of lisa_ssa_operand_fetch_if
//                (decode handshake, regfile read ports, execute handshake,
//                 stall_count)
// bus.in_ready is combinational. It depends on the state and on out_ready,
// so that a new instruction can be accepted on the same edge as the
// execute handshake. All other outputs are registered.
module lisa_ssa_operand_fetch #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    rst_n,
  lisa_ssa_operand_fetch_if.master bus
);

  localparam int unsigned WAIT_W = 16;
  localparam int unsigned CNT_W  = 32;
  localparam logic        TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((TIMEOUT == 0) ? 0 : (TIMEOUT - 1));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [7:0]        src0_q, src1_q, src2_q;
  logic [2:0]        use_q;
  logic [TAG_W-1:0]  tag_q;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  stall_q;
  logic [DATA_W-1:0] op0_q, op1_q, op2_q;
  logic [TAG_W-1:0]  out_tag_q;
  logic              out_err_q;
  logic              out_valid_q;

  logic [2:0] rvalid_v;
  logic       all_ok;
  logic       timeout_hit;
  logic       in_ready_c;
  logic       accept;
  logic       capture;
  logic       unmet;

  assign rvalid_v = {bus.rvalid2, bus.rvalid1, bus.rvalid0};

  // Next state plus the handshake and wait qualifiers.
  always_comb begin
    state_d     = state_q;
    all_ok      = &(~use_q | rvalid_v);
    in_ready_c  = (state_q == S_IDLE) | ((state_q == S_OUT) & bus.out_ready);
    accept      = bus.in_valid & in_ready_c;
    unmet       = (state_q == S_WAIT) & ~all_ok;
    timeout_hit = TIMEOUT_EN & unmet & (wait_q == WAIT_LAST);
    capture     = (state_q == S_WAIT) & (all_ok | timeout_hit);

    case (state_q)
      S_IDLE: if (accept) state_d = S_WAIT;
      S_WAIT: if (capture) state_d = S_OUT;
      S_OUT: begin
        if (bus.out_ready) state_d = accept ? S_WAIT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Instruction latch, wait/stall counters and bundle capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src0_q      <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      use_q       <= '0;
      tag_q       <= '0;
      wait_q      <= '0;
      stall_q     <= '0;
      op0_q       <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      out_tag_q   <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        src0_q <= bus.in_src0;
        src1_q <= bus.in_src1;
        src2_q <= bus.in_src2;
        use_q  <= bus.in_use;
        tag_q  <= bus.in_tag;
        wait_q <= '0;
      end else if (unmet) begin
        wait_q <= wait_q + WAIT_W'(1);
      end

      if (unmet && (stall_q != {CNT_W{1'b1}})) stall_q <= stall_q + CNT_W'(1);

      // A slot that is unused, or still invalid at timeout, is captured as 0.
      if (capture) begin
        op0_q     <= (use_q[0] & bus.rvalid0) ? bus.rdata0 : '0;
        op1_q     <= (use_q[1] & bus.rvalid1) ? bus.rdata1 : '0;
        op2_q     <= (use_q[2] & bus.rvalid2) ? bus.rdata2 : '0;
        out_tag_q <= tag_q;
        out_err_q <= ~all_ok;
      end

      out_valid_q <= (state_d == S_OUT);
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.raddr0      = src0_q;
  assign bus.raddr1      = src1_q;
  assign bus.raddr2      = src2_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_op0     = op0_q;
  assign bus.out_op1     = op1_q;
  assign bus.out_op2     = op2_q;
  assign bus.out_tag     = out_tag_q;
  assign bus.out_err     = out_err_q;
  assign bus.stall_count = stall_q;

endmodule
